// File: rtl/cpu_rst_ctrl.sv
// Reset/run-control sequencer for the MIPS core: sync release, stretched reset.
// Optional halt/run and single-step support under macro CPU_STEP_EN.
module cpu_rst_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic clkin,
  input  logic reset,
  input  logic run_mode,
  input  logic step_req,
  output logic cpu_reset,
  output logic cpu_clk_en,
  output logic ready,
  output logic step_ack
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    S_RESET,
    S_HOLD,
`ifdef CPU_STEP_EN
    S_HALT,
    S_STEP,
`endif
    S_RUN
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   sync;

  logic rst_n, en_n, rdy_n, ack_n;

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef CPU_STEP_EN
  logic step_d;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) step_d <= 1'b0;
    else        step_d <= step_req;
  end
`else
  logic unused_in;
  assign unused_in = run_mode ^ step_req;
`endif

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt    <= '0;
      state  <= S_RESET;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      if (state == S_HOLD && cnt < HOLD_MAX)
        cnt <= cnt + 1'b1;
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_RESET: if (sync) state_n = S_HOLD;
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
`ifdef CPU_STEP_EN
          state_n = run_mode ? S_RUN : S_HALT;
`else
          state_n = S_RUN;
`endif
        end
      end
`ifdef CPU_STEP_EN
      S_RUN:  if (!run_mode) state_n = S_HALT;
      S_HALT: begin
        // run request has priority over a coincident step edge
        if (run_mode)               state_n = S_RUN;
        else if (step_req && !step_d) state_n = S_STEP;
      end
      S_STEP: state_n = S_HALT;
`else
      S_RUN:  state_n = S_RUN;
`endif
      default: state_n = S_RESET;
    endcase
  end

  // outputs decoded from next state so they are registered with it
  always_comb begin
    rst_n = 1'b1;
    en_n  = 1'b0;
    rdy_n = 1'b0;
    ack_n = 1'b0;
    unique case (state_n)
      S_RESET: ;
      S_HOLD:  en_n = 1'b1;
      S_RUN: begin
        rst_n = 1'b0;
        en_n  = 1'b1;
        rdy_n = 1'b1;
      end
`ifdef CPU_STEP_EN
      S_HALT: begin
        rst_n = 1'b0;
        rdy_n = 1'b1;
      end
      S_STEP: begin
        rst_n = 1'b0;
        en_n  = 1'b1;
        rdy_n = 1'b1;
        ack_n = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      cpu_reset  <= 1'b1;
      cpu_clk_en <= 1'b0;
      ready      <= 1'b0;
      step_ack   <= 1'b0;
    end else begin
      cpu_reset  <= rst_n;
      cpu_clk_en <= en_n;
      ready      <= rdy_n;
      step_ack   <= ack_n;
    end
  end

endmodule

// File: tb/tb_cpu_rst_ctrl.sv
// Directed bench for cpu_rst_ctrl; checks {cpu_reset,cpu_clk_en,ready,step_ack}.
// Step/halt vectors are used only when CPU_STEP_EN is defined.
module tb_cpu_rst_ctrl;

  logic clkin = 1'b0;
  logic reset = 1'b0;
  logic run_mode = 1'b1;
  logic step_req = 1'b0;
  logic cpu_reset, cpu_clk_en, ready, step_ack;

  int tests = 0;
  int fails = 0;
  int acks;

  always #100 clkin = ~clkin;

  cpu_rst_ctrl dut (
    .clkin      (clkin),
    .reset      (reset),
    .run_mode   (run_mode),
    .step_req   (step_req),
    .cpu_reset  (cpu_reset),
    .cpu_clk_en (cpu_clk_en),
    .ready      (ready),
    .step_ack   (step_ack)
  );

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] got;
    got = {cpu_reset, cpu_clk_en, ready, step_ack};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got rst/en/rdy/ack=%b want %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #50;
  endtask

  task automatic seq(input string tag, input logic fin_en);
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e <= 2)      chk($sformatf("%s E%0d", tag, e), 4'b1000);
      else if (e <= 6) chk($sformatf("%s E%0d", tag, e), 4'b1100);
      else             chk($sformatf("%s E%0d", tag, e), {1'b0, fin_en, 2'b10});
    end
  endtask

  task automatic glitch(input string tag);
    #20 reset = 1'b0;
    #10 chk({tag, " async"}, 4'b1000);
    #20 reset = 1'b1;
  endtask

  initial begin
    #350;
    chk("reset state", 4'b1000);
    #50 reset = 1'b1;
    seq("release", 1'b1);
    tick();
    chk("run hold", 4'b0110);

    glitch("midrun");
    seq("rerun", 1'b1);

`ifdef CPU_STEP_EN
    run_mode = 1'b0;
    tick();
    chk("to halt", 4'b0010);

    step_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("held step c%0d", i), (i == 0) ? 4'b0111 : 4'b0010);
    end
    step_req = 1'b0;
    tick();

    acks = 0;
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b1;
      tick();
      acks += int'(step_ack);
      step_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        acks += int'(step_ack);
      end
    end
    tests++;
    if (acks != 3) begin
      fails++;
      $display("FAIL three steps: got %0d acks want 3", acks);
    end
    chk("after steps", 4'b0010);

    run_mode = 1'b1;
    step_req = 1'b1;
    tick();
    chk("collide run", 4'b0110);
    tick();
    chk("collide no ack", 4'b0110);
    run_mode = 1'b0;
    tick();
    chk("collide halt", 4'b0010);
    tick();
    chk("held level no step", 4'b0010);
    step_req = 1'b0;

    glitch("halt rst");
    seq("halt seq", 1'b0);
`else
    run_mode = 1'b0;
    glitch("nostep rst");
    seq("nostep seq", 1'b1);
    for (int i = 0; i < 6; i++) begin
      step_req = ~step_req;
      tick();
      chk($sformatf("nostep toggle %0d", i), 4'b0110);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_rst_ctrl.md
# cpu_rst_ctrl

Reset and run-control sequencer for the single-cycle MIPS core. It turns a raw asynchronous active-low board reset into a clean, synchronously released, stretched active-high `reset` for `top`, and gates the core with a clock enable. With the step feature compiled in, it also supports halt/run and single-instruction stepping. It is the hardware counterpart of the bench stimulus that drives `clkin`/`reset` into `top`, and sits between the board pins and the core.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: reset-release synchronizer depth; must be ≥2.
- `HOLD_CYCLES`, default 4: cycles `cpu_reset` stays high after synchronized release; must be ≥1.
- `CNT_W`, default 8: hold counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- `clkin` input, 1 bit: system clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low external reset.
- `run_mode` input, 1 bit: 1 = free-run, 0 = halt. Synchronous to `clkin`.
- `step_req` input, 1 bit: a rising edge requests one instruction. Debounced and synchronous to `clkin`.
- `cpu_reset` output, 1 bit: active-high reset to the core.
- `cpu_clk_en` output, 1 bit: core clock enable; the core advances one instruction per cycle while this is high.
- `ready` output, 1 bit: high once the reset sequence has completed.
- `step_ack` output, 1 bit: one-cycle pulse when a step executes.

## Operation
- The FSM has five states: RESET, HOLD, RUN, HALT, STEP. All outputs are registered (Moore).
- Asynchronous entry: while `reset`=0, the block is forced to state RESET.
  - Sync chain cleared, counter 0, `step_d` 0.
  - Outputs: `cpu_reset`=1, `cpu_clk_en`=0, `ready`=0, `step_ack`=0.
  - Assertion takes effect immediately, mid-operation included, without waiting for a clock edge.
- Release: the sync chain shifts in 1 each edge.
- RESET→HOLD on the edge where the sync output is 1.
- HOLD:
  - Outputs: `cpu_reset`=1, `cpu_clk_en`=1, so the core's synchronous registers clear.
  - The counter increments each cycle.
  - After HOLD_CYCLES cycles, the next state is RUN if `run_mode`=1, otherwise HALT.
  - `run_mode` and `step_req` are ignored during HOLD.
- RUN: `cpu_reset`=0, `cpu_clk_en`=1, `ready`=1. Goes to HALT when `run_mode`=0 is sampled.
- HALT: `cpu_clk_en`=0, `ready`=1.
  - Goes to RUN when `run_mode`=1 is sampled.
  - Otherwise goes to STEP when a rising edge is detected (`step_req`=1 and `step_d`=0).
- STEP:
  - Outputs: `cpu_clk_en`=1 and `step_ack`=1 for exactly one cycle.
  - Always returns to HALT on the next edge, regardless of `run_mode`.
- Simultaneous events:
  - `run_mode`=1 together with a step edge in HALT: RUN wins, the step is dropped, and no `step_ack` is issued.
  - A step edge while in RUN or STEP is discarded and is not queued.
  - `step_d` updates every cycle in every state, so a level held high across HALT entry does not trigger a step.
- Counter saturates at HOLD_CYCLES. There is no wrap.

## Timing
- Let E1 be the first `clkin` rising edge after `reset` goes high.
  - The sync output is 1 after edge E(SYNC_STAGES).
  - HOLD is entered at edge E(SYNC_STAGES+1).
  - `cpu_reset` falls and `ready` rises at edge E(SYNC_STAGES+HOLD_CYCLES+1). With the defaults this is E7.
- Step latency:
  - A step edge sampled at edge N gives `cpu_clk_en`=`step_ack`=1 in the cycle after N.
  - Both drop after edge N+1.
- Run/halt latency is one cycle from the sampling edge.
- A reset glitch of any width shorter than one cycle fully restarts the sequence.

## Configuration
- Macro `CPU_STEP_EN`.
- Defined: the step and halt logic described above is present.
- Undefined:
  - The STEP and HALT states and the `step_d` register are omitted.
  - HOLD always goes to RUN, and `run_mode` and `step_req` are ignored.
  - `step_ack` is tied to 0.
  - `cpu_clk_en`=1 whenever `ready`=1.

## Test plan
- Reset release: hold `reset`=0 for 400 ns at a 200 ns period, then release with `run_mode`=1 and defaults. Required: `cpu_reset`=1 and `ready`=0 through E6, `cpu_reset`=0 and `ready`=1 after E7, `cpu_clk_en`=1 continuously from HOLD onward.
- Mid-run reset: in RUN, pulse `reset` low for 30 ns between edges. Required: `cpu_reset`=1 and `cpu_clk_en`=0 immediately, before the next edge, then the full 7-edge sequence repeats.
- Single step: with `CPU_STEP_EN` and `run_mode`=0, reach HALT, then raise and hold `step_req` for 5 cycles. Required: exactly one cycle of `cpu_clk_en`=1 with `step_ack`=1, then `cpu_clk_en`=0.
- Three steps: pulse `step_req` 3 times, 4 cycles apart. Required: exactly 3 `step_ack` pulses.
- Run/step collision: in HALT, raise `run_mode` and `step_req` on the same edge. Required: RUN next cycle and no `step_ack`. Then drop `run_mode`: `cpu_clk_en`=0 one cycle later.
- Step compiled out: without `CPU_STEP_EN`, `run_mode`=0, toggle `step_req`. Required: RUN after E7, `cpu_clk_en` stays 1, `step_ack` stays 0.
